// File: rtl/ysyx_23060208_ifu_fetch.sv
// ----------------------------------------------------------------------------
// ysyx_23060208_ifu_fetch
//
// Instruction fetch unit. It takes one PC from the PC register, issues a
// single AXI4-Lite read for it, captures the returned word and presents it
// to the decoder together with its address and a fault flag. Only one read
// is ever in flight; the unit walks IDLE -> ADDR -> DATA -> HOLD -> IDLE.
//
// Parameters
//   DATA_WIDTH  width of pc, araddr, rdata, inst and inst_pc (default 32)
//
// Optional feature (compile-time macro)
//   YSYX_23060208_IFU_ALIGN_CHECK_EN
//     When defined, a pc whose two low bits are not zero is not fetched.
//     It goes straight to HOLD with fault=1 and inst=0, and no AR
//     transaction is issued. When undefined, every pc is fetched.
//
// Ports
//   clock      single clock, all state updates on its rising edge
//   reset      asynchronous, active-high reset
//   pc         fetch address from the PC register
//   pc_valid   pc holds a new address to fetch
//   pc_ready   unit accepts pc this cycle (IDLE only)
//   araddr     AXI4-Lite read address (always equals inst_pc)
//   arvalid    read address valid (ADDR only)
//   arready    read address accepted by the slave
//   rdata      read data
//   rresp      read response, 2'b00 = OKAY
//   rvalid     read data valid
//   rready     unit accepts read data (DATA only)
//   inst       fetched instruction
//   inst_pc    address of inst
//   fault      fetch fault (bad rresp, or misalignment when enabled)
//   out_valid  inst, inst_pc and fault are valid (HOLD only)
//   out_ready  decoder accepts inst
// ----------------------------------------------------------------------------
module ysyx_23060208_ifu_fetch #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  pc_valid,
  output logic                  pc_ready,

  output logic [DATA_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,

  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,

  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  output logic                  fault,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] inst_pc_reg;
  logic [DATA_WIDTH-1:0] inst_pc_next;
  logic [DATA_WIDTH-1:0] inst_reg;
  logic [DATA_WIDTH-1:0] inst_next;
  logic                  fault_reg;
  logic                  fault_next;

  // The state register resets to IDLE, but pc_ready must stay low while
  // reset is held. This flag is cleared by reset and set on the first
  // rising edge afterwards, so pc_ready remains a pure register decode
  // rather than a combinational function of the reset pin.
  logic                  run_reg;

  logic                  pc_fire;
  logic                  misaligned;

  // --------------------------------------------------------------------------
  // Moore outputs: decoded from registered state only.
  // --------------------------------------------------------------------------
  assign pc_ready  = (state_reg == IDLE) && run_reg;
  assign arvalid   = (state_reg == ADDR);
  assign rready    = (state_reg == DATA);
  assign out_valid = (state_reg == HOLD);

  // The address register doubles as the reported instruction address, so
  // araddr is stable for the whole arvalid interval by construction.
  assign araddr    = inst_pc_reg;
  assign inst_pc   = inst_pc_reg;
  assign inst      = inst_reg;
  assign fault     = fault_reg;

  assign pc_fire   = pc_valid && pc_ready;

`ifdef YSYX_23060208_IFU_ALIGN_CHECK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State and datapath registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      inst_pc_reg <= '0;
      inst_reg    <= '0;
      fault_reg   <= 1'b0;
      run_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      inst_pc_reg <= inst_pc_next;
      inst_reg    <= inst_next;
      fault_reg   <= fault_next;
      run_reg     <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath update.
  // Inputs that arrive outside the state that consumes them (pc_valid
  // outside IDLE, rvalid outside DATA, out_ready outside HOLD) simply fall
  // through to the hold-current-value defaults.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    inst_pc_next = inst_pc_reg;
    inst_next    = inst_reg;
    fault_next   = fault_reg;

    case (state_reg)
      IDLE: begin
        if (pc_fire) begin
          inst_pc_next = pc;
          if (misaligned) begin
            // Report the fault without touching the bus.
            inst_next  = '0;
            fault_next = 1'b1;
            state_next = HOLD;
          end else begin
            state_next = ADDR;
          end
        end
      end

      ADDR: begin
        if (arready) begin
          state_next = DATA;
        end
      end

      DATA: begin
        if (rvalid) begin
          inst_next  = rdata;
          fault_next = (rresp != 2'b00);
          state_next = HOLD;
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060208_ifu_fetch
//
// Self-checking bench for ysyx_23060208_ifu_fetch. The bench plays both the
// PC register and an AXI4-Lite slave with programmable wait states. Each
// transaction is described by (address, data, response, AR wait, R wait,
// HOLD wait); the expected cycle-by-cycle behaviour is derived from that
// description alone: arvalid one cycle after pc acceptance, rready one
// cycle after the AR handshake, out_valid one cycle after the R handshake,
// captured values equal to what the slave returned.
//
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_ysyx_23060208_ifu_fetch;

  localparam int DW = 32;

  logic          clock;
  logic          reset;
  logic [DW-1:0] pc;
  logic          pc_valid;
  logic          pc_ready;
  logic [DW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] inst;
  logic [DW-1:0] inst_pc;
  logic          fault;
  logic          out_valid;
  logic          out_ready;

  int checks   = 0;
  int failures = 0;

  ysyx_23060208_ifu_fetch #(.DATA_WIDTH(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .pc_ready  (pc_ready),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .fault     (fault),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Model: is this pc rejected without a bus access?
  function automatic bit model_misaligned(input logic [31:0] a);
`ifdef YSYX_23060208_IFU_ALIGN_CHECK_EN
    return (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // One complete fetch, driven and checked against the transaction model.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] resp, input int arw, input int rw,
                         input int hw);
    logic [31:0] exp_inst;
    logic        exp_fault;
    int          n;
    bit          bad;

    bad       = model_misaligned(addr);
    exp_inst  = bad ? 32'h0 : data;
    exp_fault = bad ? 1'b1 : (resp != 2'b00);

    // Offer the pc; the unit should be idle and ready already.
    pc       = addr;
    pc_valid = 1'b1;
    n = 0;
    while (!pc_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_val("pc_ready_idle", {31'b0, pc_ready}, 32'd1);
    check_val("arvalid_before_accept", {31'b0, arvalid}, 32'd0);
    @(negedge clock);                        // cycle N+1
    pc_valid = 1'b0;
    pc       = $urandom;

    if (!bad) begin
      check_val("arvalid_n1", {31'b0, arvalid}, 32'd1);
      check_val("araddr", araddr, addr);
      for (int i = 0; i < arw; i++) begin
        arready   = 1'b0;
        rvalid    = 1'($urandom);            // stray rvalid must be ignored
        rdata     = $urandom;
        out_ready = 1'($urandom);
        @(negedge clock);
        check_val("arvalid_wait", {31'b0, arvalid}, 32'd1);
        check_val("araddr_stable", araddr, addr);
        check_val("rready_in_addr", {31'b0, rready}, 32'd0);
      end
      arready = 1'b1;
      rvalid  = 1'b0;
      @(negedge clock);                      // AR handshake done
      arready = 1'b0;
      check_val("rready", {31'b0, rready}, 32'd1);
      check_val("arvalid_after_ar", {31'b0, arvalid}, 32'd0);
      for (int i = 0; i < rw; i++) begin
        rvalid    = 1'b0;
        out_ready = 1'($urandom);
        @(negedge clock);
        check_val("rready_wait", {31'b0, rready}, 32'd1);
        check_val("out_valid_early", {31'b0, out_valid}, 32'd0);
      end
      rvalid = 1'b1;
      rdata  = data;
      rresp  = resp;
      @(negedge clock);                      // R handshake done
      rvalid = 1'b0;
      rdata  = $urandom;
      rresp  = 2'($urandom);
      check_val("rready_after_r", {31'b0, rready}, 32'd0);
    end else begin
      check_val("arvalid_misaligned", {31'b0, arvalid}, 32'd0);
    end

    check_val("out_valid", {31'b0, out_valid}, 32'd1);
    check_val("inst", inst, exp_inst);
    check_val("inst_pc", inst_pc, addr);
    check_val("fault", {31'b0, fault}, {31'b0, exp_fault});

    // Back-pressure from the decoder with pc_valid and rvalid noise.
    for (int i = 0; i < hw; i++) begin
      out_ready = 1'b0;
      pc_valid  = 1'($urandom);
      pc        = $urandom;
      rvalid    = 1'($urandom);
      rdata     = $urandom;
      @(negedge clock);
      check_val("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check_val("hold_inst", inst, exp_inst);
      check_val("hold_inst_pc", inst_pc, addr);
      check_val("hold_fault", {31'b0, fault}, {31'b0, exp_fault});
      check_val("hold_pc_ready", {31'b0, pc_ready}, 32'd0);
      check_val("hold_arvalid", {31'b0, arvalid}, 32'd0);
    end
    out_ready = 1'b1;
    pc_valid  = 1'b0;
    rvalid    = 1'b0;
    @(negedge clock);
    out_ready = 1'b0;
    check_val("out_valid_after_ready", {31'b0, out_valid}, 32'd0);
    check_val("pc_ready_after_ready", {31'b0, pc_ready}, 32'd1);

    $display("txn addr=%h data=%h resp=%0d arw=%0d rw=%0d hw=%0d -> inst=%h fault=%0d",
             addr, data, resp, arw, rw, hw, exp_inst, exp_fault);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pc_ready"}, {31'b0, pc_ready}, 32'd0);
    check_val({tag, "_arvalid"}, {31'b0, arvalid}, 32'd0);
    check_val({tag, "_rready"}, {31'b0, rready}, 32'd0);
    check_val({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check_val({tag, "_inst"}, inst, 32'd0);
    check_val({tag, "_inst_pc"}, inst_pc, 32'd0);
    check_val({tag, "_araddr"}, araddr, 32'd0);
    check_val({tag, "_fault"}, {31'b0, fault}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    pc        = '0;
    pc_valid  = 1'b0;
    arready   = 1'b0;
    rdata     = '0;
    rresp     = 2'b00;
    rvalid    = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    check_val("pc_ready_before_edge", {31'b0, pc_ready}, 32'd0);
    @(negedge clock);
    check_val("pc_ready_first_edge", {31'b0, pc_ready}, 32'd1);

    // Directed cases.
    run_txn(32'h2000_0000, 32'h0000_0413, 2'b00, 0, 0, 0);
    run_txn(32'h2000_0004, 32'h1234_5678, 2'b00, 3, 2, 0);
    run_txn(32'h2000_0008, 32'hDEAD_BEEF, 2'b10, 0, 0, 0);
    run_txn(32'h2000_000C, 32'h00A0_0093, 2'b00, 1, 1, 4);
`ifdef YSYX_23060208_IFU_ALIGN_CHECK_EN
    run_txn(32'h2000_0002, 32'h5555_AAAA, 2'b00, 0, 0, 0);
`endif

    // Reset in the middle of DATA, then a stray response after release.
    pc       = 32'h3000_0000;
    pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    arready  = 1'b1;
    @(negedge clock);
    arready  = 1'b0;
    check_val("mid_rready", {31'b0, rready}, 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    @(negedge clock);
    reset  = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hCAFE_F00D;
    rresp  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_val("stray_out_valid", {31'b0, out_valid}, 32'd0);
      check_val("stray_rready", {31'b0, rready}, 32'd0);
      check_val("stray_pc_ready", {31'b0, pc_ready}, 32'd1);
    end
    rvalid = 1'b0;
    run_txn(32'h2000_0010, 32'h0010_0073, 2'b00, 0, 1, 1);

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      logic [31:0] a;
      logic [1:0]  r;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      r = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      run_txn(a, $urandom, r, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
